// File: rtl/fp_accum_pkg.sv
// Shared definitions for the float accumulation sequencer: word width,
// FSM state encoding and the IEEE-754 zero test used by the optional
// zero-skip path (FP_ACC_ZERO_SKIP_EN).
package fp_accum_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      S_FIRST = 2'd0,
      S_TERM  = 2'd1,
      S_ISSUE = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   localparam logic [DATA_W-1:0] FP_POS_ZERO = 32'h0000_0000;

   // True for +0.0 and -0.0 (sign bit ignored).
   function automatic logic fp_is_zero(input logic [DATA_W-1:0] word);
      return (word[30:0] == 31'd0);
   endfunction

endpackage

// File: rtl/fp_accum_sequencer.sv
// fp_accum_sequencer: folds each group of N_TERMS IEEE-754 single terms into
// one sum by handing (running sum, next term) pairs to an external adder and
// capturing its result on done. The first term of a group is loaded straight
// into the accumulator without an adder pass.
//
// Optional build macro FP_ACC_ZERO_SKIP_EN: when defined, a +/-0.0 term after
// the first is counted but never sent to the adder, so the accumulator (and
// the sign of a -0 running sum) is held.
//
// All handshake outputs are flops, so none of in_valid, done or sum_ready
// reaches an output combinationally.
module fp_accum_sequencer #(
   parameter int N_TERMS = 4,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              x_rdy,
   output logic              y_rdy,
   output logic [DATA_W-1:0] x_data,
   output logic [DATA_W-1:0] y_data,
   input  logic              done,
   input  logic [DATA_W-1:0] z_data,
   output logic              sum_valid,
   output logic [DATA_W-1:0] sum_data,
   input  logic              sum_ready,
   output logic              busy
);

   import fp_accum_pkg::*;

   localparam int CNT_W = $clog2(N_TERMS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS);

   state_t            state;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] term_reg;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic              last_term;

   // The running sum and current term feed the adder directly; the finished
   // sum is simply the accumulator, which is frozen while S_OUT waits.
   assign x_data   = acc;
   assign y_data   = term_reg;
   assign sum_data = acc;

   // Term count after the operation now completing; reaching N_TERMS ends the group.
   assign cnt_inc   = cnt + CNT_W'(1);
   assign last_term = (cnt_inc == LAST);

   // Sequencer FSM with registered handshake outputs set alongside each transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FIRST;
         acc       <= FP_POS_ZERO;
         term_reg  <= FP_POS_ZERO;
         cnt       <= '0;
         in_ready  <= 1'b1;
         x_rdy     <= 1'b0;
         y_rdy     <= 1'b0;
         sum_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_FIRST: begin
               if (in_valid) begin
                  acc  <= in_data;
                  cnt  <= CNT_W'(1);
                  busy <= 1'b1;
                  if (N_TERMS == 1) begin
                     state     <= S_OUT;
                     in_ready  <= 1'b0;
                     sum_valid <= 1'b1;
                  end else begin
                     state <= S_TERM;
                  end
               end
            end

            S_TERM: begin
               if (in_valid) begin
`ifdef FP_ACC_ZERO_SKIP_EN
                  if (fp_is_zero(in_data)) begin
                     // Adding a zero cannot change a nonzero sum, and holding
                     // acc keeps the sign of -0 + -0.
                     cnt <= cnt_inc;
                     if (last_term) begin
                        state     <= S_OUT;
                        in_ready  <= 1'b0;
                        sum_valid <= 1'b1;
                     end
                  end else begin
                     term_reg <= in_data;
                     state    <= S_ISSUE;
                     in_ready <= 1'b0;
                     x_rdy    <= 1'b1;
                     y_rdy    <= 1'b1;
                  end
`else
                  term_reg <= in_data;
                  state    <= S_ISSUE;
                  in_ready <= 1'b0;
                  x_rdy    <= 1'b1;
                  y_rdy    <= 1'b1;
`endif
               end
            end

            S_ISSUE: begin
               if (done) begin
                  acc   <= z_data;
                  cnt   <= cnt_inc;
                  x_rdy <= 1'b0;
                  y_rdy <= 1'b0;
                  if (last_term) begin
                     state     <= S_OUT;
                     sum_valid <= 1'b1;
                  end else begin
                     state    <= S_TERM;
                     in_ready <= 1'b1;
                  end
               end
            end

            S_OUT: begin
               if (sum_ready) begin
                  state     <= S_FIRST;
                  sum_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end

            default: begin
               state     <= S_FIRST;
               in_ready  <= 1'b1;
               x_rdy     <= 1'b0;
               y_rdy     <= 1'b0;
               sum_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_accum_sequencer.sv
// Bench for fp_accum_sequencer: three instances (N_TERMS = 1, 2, 4) share one
// clock and reset, each served by a behavioural float adder with programmable
// latency. Build with FP_ACC_ZERO_SKIP_EN defined to exercise the zero-skip path.
module tb_fp_accum_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid  [3];
   logic [31:0] in_data   [3];
   logic        in_ready  [3];
   logic        x_rdy     [3];
   logic        y_rdy     [3];
   logic [31:0] x_data    [3];
   logic [31:0] y_data    [3];
   logic        done      [3];
   logic [31:0] z_data    [3];
   logic        sum_valid [3];
   logic [31:0] sum_data  [3];
   logic        sum_ready [3];
   logic        busy      [3];

`ifdef FP_ACC_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   fp_accum_sequencer #(.N_TERMS(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_ready(in_ready[0]), .x_rdy(x_rdy[0]), .y_rdy(y_rdy[0]), .x_data(x_data[0]),
      .y_data(y_data[0]), .done(done[0]), .z_data(z_data[0]), .sum_valid(sum_valid[0]),
      .sum_data(sum_data[0]), .sum_ready(sum_ready[0]), .busy(busy[0]));

   fp_accum_sequencer #(.N_TERMS(2)) u_n2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_ready(in_ready[1]), .x_rdy(x_rdy[1]), .y_rdy(y_rdy[1]), .x_data(x_data[1]),
      .y_data(y_data[1]), .done(done[1]), .z_data(z_data[1]), .sum_valid(sum_valid[1]),
      .sum_data(sum_data[1]), .sum_ready(sum_ready[1]), .busy(busy[1]));

   fp_accum_sequencer #(.N_TERMS(4)) u_n4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_data(in_data[2]),
      .in_ready(in_ready[2]), .x_rdy(x_rdy[2]), .y_rdy(y_rdy[2]), .x_data(x_data[2]),
      .y_data(y_data[2]), .done(done[2]), .z_data(z_data[2]), .sum_valid(sum_valid[2]),
      .sum_data(sum_data[2]), .sum_ready(sum_ready[2]), .busy(busy[2]));

   // ---------------- float helpers (single <-> double, exact add) ----------
   function automatic real f2d(input logic [31:0] f);
      logic [63:0] b;
      if (f[30:0] == 31'd0) b = {f[31], 63'd0};
      else b = {f[31], 11'({3'b000, f[30:23]}) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(b);
   endfunction

   // Round a double to single, nearest-even; operands here stay normal.
   function automatic logic [31:0] d2f(input real r);
      logic [63:0] b;
      logic [24:0] m;
      int          e;
      b = $realtobits(r);
      if (b[62:52] == 11'd0) return {b[63], 31'd0};
      m = {2'b01, b[51:29]};
      if (b[28] && ((|b[27:0]) || m[0])) m = m + 25'd1;
      e = int'(b[62:52]) - 896;
      if (m[24]) begin
         e = e + 1;
         m = m >> 1;
      end
      return {b[63], e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return d2f(f2d(a) + f2d(b));
   endfunction

   // ---------------- behavioural adder per instance --------------------------
   int          lat  [3] = '{1, 1, 1};
   bit          spur [3] = '{0, 0, 0};
   int          ops  [3] = '{0, 0, 0};
   int          win  [3] = '{0, 0, 0};
   int          stab [3] = '{0, 0, 0};
   bit          pend [3] = '{0, 0, 0};
   bit          fired[3] = '{0, 0, 0};
   int          wcnt [3] = '{0, 0, 0};
   logic [31:0] wx   [3];
   logic [31:0] wy   [3];
   logic [31:0] xlog [3][8];
   logic [31:0] ylog [3][8];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         done[i] = 1'b0;
         if (!rst_n) begin
            pend[i]  = 1'b0;
            fired[i] = 1'b0;
         end else if (x_rdy[i] && y_rdy[i]) begin
            if (!pend[i]) begin
               pend[i] = 1'b1;
               wcnt[i] = 0;
               win[i]  = win[i] + 1;
               wx[i]   = x_data[i];
               wy[i]   = y_data[i];
            end else if (x_data[i] !== wx[i] || y_data[i] !== wy[i]) begin
               stab[i] = stab[i] + 1;
            end
            if (!fired[i]) begin
               if (wcnt[i] >= lat[i]) begin
                  done[i]  = 1'b1;
                  z_data[i] = fadd(x_data[i], y_data[i]);
                  fired[i] = 1'b1;
                  xlog[i][ops[i] % 8] = x_data[i];
                  ylog[i][ops[i] % 8] = y_data[i];
                  ops[i] = ops[i] + 1;
               end else begin
                  wcnt[i] = wcnt[i] + 1;
               end
            end
         end else begin
            pend[i]  = 1'b0;
            fired[i] = 1'b0;
         end
         if (spur[i] && !done[i]) begin
            done[i]   = 1'b1;
            z_data[i] = 32'h4B00_0000;
         end
      end
   end

   // ---------------- checking infrastructure ---------------------------------
   int ncmp = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic send(input int i, input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      in_valid[i] = 1'b1;
      in_data[i]  = d;
      while (!in_ready[i] && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[i]) begin
         ncmp++;
         nerr++;
         $display("FAIL send_timeout inst %0d: in_ready 0 required 1", i);
         in_valid[i] = 1'b0;
      end else begin
         @(posedge clk);
         #1 in_valid[i] = 1'b0;
      end
   endtask

   task automatic get_sum(input int i, input int dly, output logic [31:0] d);
      int n = 0;
      @(negedge clk);
      while (!sum_valid[i] && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!sum_valid[i]) begin
         ncmp++;
         nerr++;
         $display("FAIL sum_timeout inst %0d: sum_valid 0 required 1", i);
         d = '0;
      end else begin
         repeat (dly) @(negedge clk);
         d = sum_data[i];
         sum_ready[i] = 1'b1;
         @(posedge clk);
         #1 sum_ready[i] = 1'b0;
      end
   endtask

   // ---------------- directed vector table -----------------------------------
   typedef struct packed {
      int               inst;
      int               n;
      logic [3:0][31:0] t;
      logic [31:0]      sum;
      int               nops;
      logic [2:0][31:0] x;
      logic [31:0]      y0;
   } vec_t;

   function automatic vec_t mk(input int inst, input int n,
                               input logic [31:0] t0, input logic [31:0] t1,
                               input logic [31:0] t2, input logic [31:0] t3,
                               input logic [31:0] sum, input int nops,
                               input logic [31:0] x0, input logic [31:0] x1,
                               input logic [31:0] x2, input logic [31:0] y0);
      vec_t v;
      v.inst = inst; v.n = n;
      v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
      v.sum = sum; v.nops = nops;
      v.x[0] = x0; v.x[1] = x1; v.x[2] = x2;
      v.y0 = y0;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vt [6];
      logic [31:0] s;
      logic [31:0] t  [4];
      logic [31:0] ex;
      int          eops, b0, w0, n;

      vt[0] = mk(1, 2, 32'h40033333, 32'h3F828F5C, 0, 0, 32'h40447AE1, 1,
                 32'h40033333, 0, 0, 32'h3F828F5C);
      vt[1] = mk(2, 4, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h41200000, 3, 32'h3F800000, 32'h40400000, 32'h40C00000, 32'h40000000);
      vt[2] = mk(0, 1, 32'h40490FDB, 0, 0, 0, 32'h40490FDB, 0, 0, 0, 0, 0);
      vt[3] = mk(2, 4, 32'h3F800000, 32'h80000000, 32'h00000000, 32'h3F800000,
                 32'h40000000, SKIP ? 1 : 3, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                 SKIP ? 32'h3F800000 : 32'h80000000);
      vt[4] = mk(1, 2, 32'h80000000, 32'h80000000, 0, 0, 32'h80000000, SKIP ? 0 : 1,
                 32'h80000000, 0, 0, 32'h80000000);
      vt[5] = mk(1, 2, 32'h80000000, 32'h00000000, 0, 0,
                 SKIP ? 32'h80000000 : 32'h00000000, SKIP ? 0 : 1,
                 32'h80000000, 0, 0, 32'h00000000);

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         sum_ready[i] = 1'b0;
      end
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_in_ready",  32'(in_ready[2]),  32'd1);
      chk("rst_x_rdy",     32'(x_rdy[2]),     32'd0);
      chk("rst_y_rdy",     32'(y_rdy[2]),     32'd0);
      chk("rst_sum_valid", 32'(sum_valid[2]), 32'd0);
      chk("rst_busy",      32'(busy[2]),      32'd0);
      chk("rst_x_data",    x_data[2],         32'h0);
      chk("rst_y_data",    y_data[2],         32'h0);
      chk("rst_sum_data",  sum_data[2],       32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // table-driven directed sums
      for (int v = 0; v < 6; v++) begin
         int i;
         i  = vt[v].inst;
         b0 = ops[i];
         w0 = win[i];
         lat[i] = v % 3;
         for (int k = 0; k < vt[v].n; k++) send(i, vt[v].t[k]);
         get_sum(i, 0, s);
         chk($sformatf("vec%0d_sum", v), s, vt[v].sum);
         chk($sformatf("vec%0d_ops", v), 32'(ops[i] - b0), 32'(vt[v].nops));
         chk($sformatf("vec%0d_windows", v), 32'(win[i] - w0), 32'(vt[v].nops));
         for (int k = 0; k < vt[v].nops; k++)
            chk($sformatf("vec%0d_x%0d", v, k), xlog[i][(b0 + k) % 8], vt[v].x[k]);
         if (vt[v].nops > 0)
            chk($sformatf("vec%0d_y0", v), ylog[i][b0 % 8], vt[v].y0);
      end

      // N_TERMS=1: sum_valid right after the accepting edge
      b0 = ops[0];
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data[0]  = 32'h40490FDB;
      chk("n1_ready_before", 32'(in_ready[0]), 32'd1);
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      chk("n1_sum_valid", 32'(sum_valid[0]), 32'd1);
      chk("n1_sum_data",  sum_data[0],       32'h40490FDB);
      chk("n1_in_ready",  32'(in_ready[0]),  32'd0);
      chk("n1_busy",      32'(busy[0]),      32'd1);
      get_sum(0, 0, s);
      chk("n1_ops", 32'(ops[0] - b0), 32'd0);

      // sum backpressure with in_valid held and spurious done pulses
      lat[1] = 2;
      b0 = ops[1];
      send(1, 32'h40400000);
      send(1, 32'h3F800000);
      n = 0;
      @(negedge clk);
      while (!sum_valid[1] && n < 100) begin
         @(negedge clk);
         n++;
      end
      in_valid[1] = 1'b1;
      in_data[1]  = 32'h41000000;
      for (int c = 0; c < 5; c++) begin
         spur[1] = (c % 2 == 0);
         @(negedge clk);
         chk($sformatf("bp%0d_sum_valid", c), 32'(sum_valid[1]), 32'd1);
         chk($sformatf("bp%0d_in_ready", c),  32'(in_ready[1]),  32'd0);
         chk($sformatf("bp%0d_sum_data", c),  sum_data[1],       32'h40800000);
      end
      spur[1] = 1'b0;
      sum_ready[1] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_in_ready_back", 32'(in_ready[1]),  32'd1);
      chk("bp_sum_valid_off", 32'(sum_valid[1]), 32'd0);
      in_valid[1]  = 1'b0;
      sum_ready[1] = 1'b0;
      chk("bp_ops", 32'(ops[1] - b0), 32'd1);

      // reset in the middle of an adder operation
      lat[1] = 4;
      send(1, 32'h3F800000);
      send(1, 32'h40000000);
      chk("mid_x_rdy_pre", 32'(x_rdy[1]), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_x_rdy",    32'(x_rdy[1]),    32'd0);
      chk("mid_y_rdy",    32'(y_rdy[1]),    32'd0);
      chk("mid_acc",      x_data[1],        32'h0);
      chk("mid_busy",     32'(busy[1]),     32'd0);
      chk("mid_in_ready", 32'(in_ready[1]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      b0 = ops[1];
      send(1, 32'h3F800000);
      send(1, 32'h3F800000);
      get_sum(1, 1, s);
      chk("mid_after_sum", s, 32'h40000000);
      chk("mid_after_ops", 32'(ops[1] - b0), 32'd1);

      // randomized groups against a fold-left reference
      for (int g = 0; g < 30; g++) begin
         lat[2] = $urandom_range(0, 3);
         b0 = ops[2];
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 3) == 0)
               t[k] = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h00000000;
            else
               t[k] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
         end
         ex = t[0];
         eops = 0;
         for (int k = 1; k < 4; k++) begin
            if (!(SKIP && t[k][30:0] == 31'd0)) begin
               ex = fadd(ex, t[k]);
               eops++;
            end
         end
         for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(2, t[k]);
         end
         get_sum(2, $urandom_range(0, 3), s);
         chk($sformatf("rnd%0d_sum", g), s, ex);
         chk($sformatf("rnd%0d_ops", g), 32'(ops[2] - b0), 32'(eops));
      end

      for (int i = 0; i < 3; i++)
         chk($sformatf("operand_stability_inst%0d", i), 32'(stab[i]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
